// File: rtl/i2c_slave.sv
// I2C target decoding the on-chip master's register protocol into register-file strobes.
// Optional burst addressing: define I2C_SLAVE_AUTO_INC_EN to auto-increment reg_addr_o.
`timescale 1ns/1ps

module i2c_slave #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       enable_i,
   input  logic [6:0] slave_addr_i,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_o,
   output logic       sda_oe_o,
   output logic [7:0] reg_addr_o,
   output logic       reg_we_o,
   output logic [7:0] reg_wdata_o,
   output logic       reg_re_o,
   input  logic [7:0] reg_rdata_i,
   output logic       busy_o,
   output logic       nack_o
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR,
      S_ACK_ADDR,
      S_REG,
      S_ACK_REG,
      S_WDATA,
      S_ACK_WDATA,
      S_RDATA,
      S_ACK_RD
   } state_t;

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_s;
   logic                   sda_s;
   logic                   scl_d;
   logic                   sda_d;
   logic                   start_det;
   logic                   stop_det;
   logic                   scl_rise;
   logic                   scl_fall;

   state_t                 state;
   logic [3:0]             bit_cnt;
   logic [7:0]             shift;
   logic                   rw;
   logic [7:0]             rx_byte;

   // Open-drain pad: the drive value is fixed low, only the enable toggles.
   assign sda_o = 1'b0;

   // Input synchronisers reset to the idle-bus level so reset never fakes a START.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
         scl_d    <= scl_s;
         sda_d    <= sda_s;
      end
   end

   assign scl_s     = scl_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign start_det = scl_s & scl_d & sda_d & ~sda_s;
   assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
   assign scl_rise  = scl_s & ~scl_d;
   assign scl_fall  = ~scl_s & scl_d;
   assign rx_byte   = {shift[6:0], sda_s};

   // Protocol FSM. During the ACK states sda_oe_o doubles as the phase flag:
   // the first SCL fall starts the ACK pulse, the second one ends it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= S_IDLE;
         bit_cnt     <= 4'd0;
         shift       <= 8'd0;
         rw          <= 1'b0;
         sda_oe_o    <= 1'b0;
         reg_addr_o  <= 8'd0;
         reg_we_o    <= 1'b0;
         reg_wdata_o <= 8'd0;
         reg_re_o    <= 1'b0;
         busy_o      <= 1'b0;
         nack_o      <= 1'b0;
      end else begin
         reg_we_o <= 1'b0;
         reg_re_o <= 1'b0;
         if (reg_re_o) begin
            shift <= reg_rdata_i;
         end
`ifdef I2C_SLAVE_AUTO_INC_EN
         if (reg_we_o) begin
            reg_addr_o <= reg_addr_o + 8'd1;
         end
`endif
         if (!enable_i) begin
            state    <= S_IDLE;
            sda_oe_o <= 1'b0;
            busy_o   <= 1'b0;
         end else if (start_det) begin
            state    <= S_ADDR;
            bit_cnt  <= 4'd0;
            nack_o   <= 1'b0;
            sda_oe_o <= 1'b0;
         end else if (stop_det) begin
            state    <= S_IDLE;
            sda_oe_o <= 1'b0;
            busy_o   <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  sda_oe_o <= 1'b0;
               end

               S_ADDR: begin
                  if (scl_rise) begin
                     shift <= rx_byte;
                     if (bit_cnt == 4'd7) begin
                        bit_cnt <= 4'd0;
                        if (shift[6:0] == slave_addr_i) begin
                           busy_o <= 1'b1;
                           rw     <= sda_s;
                           state  <= S_ACK_ADDR;
                        end else begin
                           busy_o <= 1'b0;
                           state  <= S_IDLE;
                        end
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
               end

               S_ACK_ADDR: begin
                  if (scl_fall) begin
                     if (!sda_oe_o) begin
                        sda_oe_o <= 1'b1;
                     end else if (rw) begin
                        sda_oe_o <= ~shift[7];
                        shift    <= {shift[6:0], 1'b0};
                        bit_cnt  <= 4'd1;
                        state    <= S_RDATA;
                     end else begin
                        sda_oe_o <= 1'b0;
                        state    <= S_REG;
                     end
                  end else if (scl_rise && sda_oe_o && rw) begin
                     reg_re_o <= 1'b1;
                  end
               end

               S_REG: begin
                  if (scl_rise) begin
                     shift <= rx_byte;
                     if (bit_cnt == 4'd7) begin
                        bit_cnt    <= 4'd0;
                        reg_addr_o <= rx_byte;
                        state      <= S_ACK_REG;
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
               end

               S_ACK_REG, S_ACK_WDATA: begin
                  if (scl_fall) begin
                     if (!sda_oe_o) begin
                        sda_oe_o <= 1'b1;
                     end else begin
                        sda_oe_o <= 1'b0;
                        state    <= S_WDATA;
                     end
                  end
               end

               S_WDATA: begin
                  if (scl_rise) begin
                     shift <= rx_byte;
                     if (bit_cnt == 4'd7) begin
                        bit_cnt     <= 4'd0;
                        reg_wdata_o <= rx_byte;
                        reg_we_o    <= 1'b1;
                        state       <= S_ACK_WDATA;
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
               end

               S_RDATA: begin
                  if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        sda_oe_o <= 1'b0;
                        bit_cnt  <= 4'd0;
                        state    <= S_ACK_RD;
                     end else begin
                        sda_oe_o <= ~shift[7];
                        shift    <= {shift[6:0], 1'b0};
                        bit_cnt  <= bit_cnt + 4'd1;
                     end
                  end
               end

               S_ACK_RD: begin
                  if (scl_rise) begin
                     if (sda_s) begin
                        nack_o <= 1'b1;
                        state  <= S_IDLE;
                     end else begin
                        reg_re_o <= 1'b1;
`ifdef I2C_SLAVE_AUTO_INC_EN
                        reg_addr_o <= reg_addr_o + 8'd1;
`endif
                        bit_cnt  <= 4'd0;
                        state    <= S_RDATA;
                     end
                  end
               end

               default: begin
                  state    <= S_IDLE;
                  sda_oe_o <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
